if_fetch_unit: RTL

//  Instruction-fetch stage of the 5-stage MIPS pipeline, on the consumer side of the stall/redirect interface

---
 rtl/if_fetch_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake,
// buffers one instruction and loads the IF/ID register. Stalls (wpcir) and
// redirects (branch/jump) from ID insert NOP bubbles.
//
// state  | meaning
// S_WAIT | buffer empty; request outstanding (or in its 1-cycle gap)
// S_FULL | buffer holds fb_instr fetched from fb_pc; no request
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wpcir,
    input  logic             branch,
    input  logic             jump,
    input  logic [31:0]      bpc,
    input  logic [31:0]      jpc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_instr,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc4,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic {S_WAIT, S_FULL} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             squash_q, squash_d;
    logic [31:0]      redir_pc_q, redir_pc_d;
    logic [31:0]      fb_instr_q, fb_instr_d;
    logic [31:0]      fb_pc_q, fb_pc_d;
    logic [31:0]      id_instr_q, id_instr_d;
    logic [31:0]      id_pc4_q, id_pc4_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic             req_q, req_d;

    logic             redir;
    logic [31:0]      target;
    logic             ack_ok;

    assign redir  = jump | branch;
    assign target = jump ? jpc : bpc;
    // An ack only counts while a request is actually on the bus.
    assign ack_ok = (state_q == S_WAIT) && req_q && imem_ack;

    // Next-state and datapath update for the fetch FSM.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        squash_d    = squash_q;
        redir_pc_d  = redir_pc_q;
        fb_instr_d  = fb_instr_q;
        fb_pc_d     = fb_pc_q;
        id_instr_d  = id_instr_q;
        id_pc4_d    = id_pc4_q;
        fetch_cnt_d = fetch_cnt_q;

        case (state_q)
            S_WAIT: begin
                id_instr_d = NOP_INSTR;
                if (ack_ok) begin
                    if (redir) begin
                        pc_d     = target;
                        squash_d = 1'b0;
                    end else if (squash_q) begin
                        pc_d     = redir_pc_q;
                        squash_d = 1'b0;
                    end else begin
                        fb_instr_d = imem_rdata;
                        fb_pc_d    = pc_q;
                        state_d    = S_FULL;
                    end
                end else if (redir) begin
                    // PC must stay put while the address is on the bus.
                    redir_pc_d = target;
                    squash_d   = 1'b1;
                end
            end
            S_FULL: begin
                if (redir) begin
                    pc_d       = target;
                    id_instr_d = NOP_INSTR;
                    state_d    = S_WAIT;
                end else if (wpcir) begin
                    id_instr_d = NOP_INSTR;
                end else begin
                    id_instr_d  = fb_instr_q;
                    id_pc4_d    = fb_pc_q + 32'd4;
                    pc_d        = fb_pc_q + 32'd4;
                    fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                    state_d     = S_WAIT;
                end
            end
            default: state_d = S_WAIT;
        endcase

        // Gap of one cycle after every accepted ack, and no request when FULL.
        req_d = (state_d == S_WAIT) && !ack_ok;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_WAIT;
            pc_q        <= RESET_PC;
            squash_q    <= 1'b0;
            redir_pc_q  <= RESET_PC;
            fb_instr_q  <= NOP_INSTR;
            fb_pc_q     <= RESET_PC;
            id_instr_q  <= NOP_INSTR;
            id_pc4_q    <= 32'h0;
            fetch_cnt_q <= '0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            squash_q    <= squash_d;
            redir_pc_q  <= redir_pc_d;
            fb_instr_q  <= fb_instr_d;
            fb_pc_q     <= fb_pc_d;
            id_instr_q  <= id_instr_d;
            id_pc4_q    <= id_pc4_d;
            fetch_cnt_q <= fetch_cnt_d;
            req_q       <= req_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign if_instr  = (state_q == S_FULL) ? fb_instr_q : NOP_INSTR;
    assign id_instr  = id_instr_q;
    assign id_pc4    = id_pc4_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule
